ss_apb_gpio: RTL

//  Parametrised APB-slave GPIO subsystem; drop-in for a student subsystem slot (APB, IRQ, SS_Ctrl, pmod GPIO).

---
 rtl/ss_apb_gpio_pkg.sv | 41 ++++
 rtl/ss_apb_gpio_if.sv | 18 +
 rtl/ss_apb_gpio_sync_edge.sv | 34 +++
 rtl/ss_apb_gpio.sv | 121 ++++++++++++
 4 files changed

// File: rtl/ss_apb_gpio_pkg.sv
// Shared constants and decode helper for the APB GPIO subsystem.
// No logic of its own; offsets are byte offsets within the 64-byte window.
// No flow control here; used by the register file decode.
package ss_apb_gpio_pkg;

    localparam int ADDR_DEC_W = 6;

    localparam logic [ADDR_DEC_W-1:0] OFS_OUT    = 6'h00;
    localparam logic [ADDR_DEC_W-1:0] OFS_OE     = 6'h04;
    localparam logic [ADDR_DEC_W-1:0] OFS_IN     = 6'h08;
    localparam logic [ADDR_DEC_W-1:0] OFS_IRQ_EN = 6'h0C;
    localparam logic [ADDR_DEC_W-1:0] OFS_RISE   = 6'h10;
    localparam logic [ADDR_DEC_W-1:0] OFS_FALL   = 6'h14;
    localparam logic [ADDR_DEC_W-1:0] OFS_STATUS = 6'h18;
    localparam logic [ADDR_DEC_W-1:0] OFS_SET    = 6'h1C;
    localparam logic [ADDR_DEC_W-1:0] OFS_CLR    = 6'h20;
    localparam logic [ADDR_DEC_W-1:0] OFS_ID     = 6'h24;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h6770_0001;

    // Legal access directions for one register offset.
    typedef struct packed {
        logic rd_ok;
        logic wr_ok;
    } reg_acc_t;

    // Misaligned or unmapped offsets fall to the default: neither direction legal.
    function automatic reg_acc_t decode_acc(input logic [ADDR_DEC_W-1:0] ofs);
        reg_acc_t acc;
        acc = '{rd_ok: 1'b0, wr_ok: 1'b0};
        case (ofs)
            OFS_OUT, OFS_OE, OFS_IRQ_EN,
            OFS_RISE, OFS_FALL, OFS_STATUS: acc = '{rd_ok: 1'b1, wr_ok: 1'b1};
            OFS_IN, OFS_ID:                 acc = '{rd_ok: 1'b1, wr_ok: 1'b0};
            OFS_SET, OFS_CLR:               acc = '{rd_ok: 1'b0, wr_ok: 1'b1};
            default:                        acc = '{rd_ok: 1'b0, wr_ok: 1'b0};
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/ss_apb_gpio_if.sv
// APB3 bus bundle between the subsystem host and the GPIO slave.
// No latency; plain wires.
// Slave never stalls: PREADY is high on every access phase.
interface ss_apb_gpio_if;
    logic [31:0] PADDR;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (output PADDR, PENABLE, PSEL, PWDATA, PWRITE,
                    input  PRDATA, PREADY, PSLVERR);
    modport slave  (input  PADDR, PENABLE, PSEL, PWDATA, PWRITE,
                    output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/ss_apb_gpio_sync_edge.sv
// Input synchroniser chain plus previous-value flop for per-pin edge detection.
// sync_o lags src_i by SYNC_STAGES cycles; rise_o/fall_o are combinational from sync and prev.
// No backpressure; free-running every cycle, independent of subsystem enable.
module gpio_sync_edge #(
    parameter int N_GPIO      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_in,
    input  logic              rst_n_i,
    input  logic [N_GPIO-1:0] src_i,
    output logic [N_GPIO-1:0] sync_o,
    output logic [N_GPIO-1:0] rise_o,
    output logic [N_GPIO-1:0] fall_o
);

    logic [SYNC_STAGES-1:0][N_GPIO-1:0] chain_q;
    logic [N_GPIO-1:0]                  prev_q;

    // Shift the raw pins through the chain; prev always tracks the synchronised value.
    always_ff @(posedge clk_in) begin
        if (!rst_n_i) begin
            chain_q <= '0;
            prev_q  <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], src_i};
            prev_q  <= chain_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = chain_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/ss_apb_gpio.sv
// APB-slave GPIO subsystem: pin register file, edge-detect status, gated level IRQ.
// Zero-wait APB; PRDATA captured in setup phase; writes commit at end of access phase.
// Never stalls the bus; errored accesses assert PSLVERR and leave all state untouched.
module ss_apb_gpio
    import ss_apb_gpio_pkg::*;
#(
    parameter int          N_GPIO      = 16,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
    input  logic              clk_in,
    input  logic              reset_int,
    ss_apb_gpio_if.slave      apb,
    input  logic              high_speed_clk,
    output logic              irq_3,
    input  logic              irq_en_1,
    input  logic [7:0]        ss_ctrl_1,
    input  logic [N_GPIO-1:0] pmod_gpi,
    output logic [N_GPIO-1:0] pmod_gpo,
    output logic [N_GPIO-1:0] pmod_gpio_oe
);

    logic [N_GPIO-1:0] out_q, oe_q, irq_en_q, rise_en_q, fall_en_q, status_q, status_d;
    logic [31:0]       prdata_q, rd_val;
    logic              pslverr_q, irq_q;
    logic [N_GPIO-1:0] sync_in, rise, fall, w1c, wdata;

    logic [ADDR_DEC_W-1:0] ofs;
    reg_acc_t              acc;
    logic                  setup, access, err, wr_commit, ss_en;

    assign ofs       = apb.PADDR[ADDR_DEC_W-1:0];
    assign acc       = decode_acc(ofs);
    assign err       = apb.PWRITE ? !acc.wr_ok : !acc.rd_ok;
    assign setup     = apb.PSEL && !apb.PENABLE;
    assign access    = apb.PSEL && apb.PENABLE;
    assign wr_commit = access && apb.PWRITE && !err;
    assign wdata     = apb.PWDATA[N_GPIO-1:0];
    assign ss_en     = ss_ctrl_1[0];

    // High-speed clock, reserved control bits and undecoded bus bits are intentionally dropped.
    logic unused_ok;
    assign unused_ok = ^{apb.PADDR[31:ADDR_DEC_W], apb.PWDATA, high_speed_clk, ss_ctrl_1[7:2]};

    gpio_sync_edge #(
        .N_GPIO      (N_GPIO),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_in  (clk_in),
        .rst_n_i (reset_int),
        .src_i   (ss_ctrl_1[1] ? out_q : pmod_gpi),
        .sync_o  (sync_in),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // Read mux; unreadable offsets return zero.
    always_comb begin
        rd_val = '0;
        case (ofs)
            OFS_OUT:    rd_val = 32'(out_q);
            OFS_OE:     rd_val = 32'(oe_q);
            OFS_IN:     rd_val = 32'(sync_in);
            OFS_IRQ_EN: rd_val = 32'(irq_en_q);
            OFS_RISE:   rd_val = 32'(rise_en_q);
            OFS_FALL:   rd_val = 32'(fall_en_q);
            OFS_STATUS: rd_val = 32'(status_q);
            OFS_ID:     rd_val = ID_VALUE;
            default:    rd_val = '0;
        endcase
    end

    // Pending-edge status: a new edge in the same cycle as a W1C keeps the bit set.
    always_comb begin
        w1c      = (wr_commit && ofs == OFS_STATUS) ? wdata : '0;
        status_d = (status_q & ~w1c) | (((rise & rise_en_q) | (fall & fall_en_q)) & {N_GPIO{ss_en}});
    end

    // Register file, bus response flops and the registered interrupt.
    always_ff @(posedge clk_in) begin
        if (!reset_int) begin
            out_q     <= '0;
            oe_q      <= '0;
            irq_en_q  <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            if (setup) begin
                prdata_q  <= (!apb.PWRITE && acc.rd_ok) ? rd_val : '0;
                pslverr_q <= err;
            end
            if (wr_commit) begin
                case (ofs)
                    OFS_OUT:    out_q     <= wdata;
                    OFS_OE:     oe_q      <= wdata;
                    OFS_IRQ_EN: irq_en_q  <= wdata;
                    OFS_RISE:   rise_en_q <= wdata;
                    OFS_FALL:   fall_en_q <= wdata;
                    OFS_SET:    out_q     <= out_q | wdata;
                    OFS_CLR:    out_q     <= out_q & ~wdata;
                    default:    ;
                endcase
            end
            status_q <= status_d;
            irq_q    <= irq_en_1 && |(status_q & irq_en_q);
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = access;
    assign apb.PSLVERR = pslverr_q && access;

    assign irq_3        = irq_q;
    assign pmod_gpo     = out_q;
    assign pmod_gpio_oe = oe_q & {N_GPIO{ss_en}};

endmodule
